// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store port sequencer of the unified RAM.
package lsu_mem_ctrl_pkg;
  localparam int cXLEN     = 32;
  localparam int cRamDepth = 1024;
  localparam int cAW       = $clog2(cRamDepth);

  typedef enum logic [1:0] {
    szByte    = 2'b00,
    szHalf    = 2'b01,
    szWord    = 2'b10,
    szIllegal = 2'b11
  } tLsSize;

  typedef struct packed {
    logic             write;
    tLsSize           size;
    logic             is_unsigned;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
  } tLsReq;

  typedef enum logic [2:0] {
    sIdle,
    sIssue,
    sLdData,
    sRmwData,
    sRmwWrite
  } tLsState;

  // Natural alignment: halves on even bytes, words on multiples of four.
  function automatic logic ls_misaligned(tLsSize size, logic [1:0] addr_lo);
    case (size)
      szHalf:    return addr_lo[0];
      szWord:    return addr_lo != 2'b00;
      szIllegal: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Lane steering for the load/store port: load extract/extend and store lane merge.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [cXLEN-1:0] word,
  input  logic [1:0]       addr_lo,
  input  tLsSize           size,
  input  logic             is_unsigned,
  input  logic [cXLEN-1:0] store_data,
  output logic [cXLEN-1:0] load_data,
  output logic [cXLEN-1:0] merged_data
);
  localparam int cLanes = cXLEN / 8;

  logic [cXLEN-1:0]  shifted;
  logic [cLanes-1:0] lane_en;
  logic [cXLEN-1:0]  store_rep;

  // Legal halves have addr_lo[0]==0, so one byte-granular shift serves all sizes.
  assign shifted = word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    case (size)
      szByte:  load_data = {{(cXLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      szHalf:  load_data = {{(cXLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    lane_en   = '1;
    store_rep = store_data;
    case (size)
      szByte: begin
        lane_en   = cLanes'(1) << addr_lo;
        store_rep = {cLanes{store_data[7:0]}};
      end
      szHalf: begin
        lane_en   = cLanes'(2'b11) << {addr_lo[1], 1'b0};
        store_rep = {(cLanes/2){store_data[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < cLanes; gi++) begin : g_lane
    assign merged_data[gi*8 +: 8] = lane_en[gi] ? store_rep[gi*8 +: 8] : word[gi*8 +: 8];
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer for RAM port B: one request at a time, RMW for sub-word stores.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic             iReqWrite,
  input  logic [1:0]       iReqSize,
  input  logic             iReqUnsigned,
  input  logic [cXLEN-1:0] iReqAddr,
  input  logic [cXLEN-1:0] iReqData,
  output logic             oRespValid,
  output logic [cXLEN-1:0] oRespData,
  output logic             oMisalign,
  output logic             oRamEn,
  output logic             oRamWEn,
  output logic [cAW-1:0]   oRamAddr,
  output logic [cXLEN-1:0] oRamData,
  input  logic [cXLEN-1:0] iRamData
);
  tLsState          state_reg, state_next;
  tLsReq            req_reg, req_next;
  logic             ram_en_reg, ram_en_next;
  logic             ram_wen_reg, ram_wen_next;
  logic [cAW-1:0]   ram_addr_reg, ram_addr_next;
  logic [cXLEN-1:0] ram_data_reg, ram_data_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [cXLEN-1:0] resp_data_reg, resp_data_next;
  logic             misalign_reg, misalign_next;
  logic [cXLEN-1:0] load_data, merged_data;
  logic             accept;
  tLsSize           in_size;
  logic             addr_unused;

  assign in_size     = tLsSize'(iReqSize);
  assign oReqReady   = (state_reg == sIdle) && iRst;
  assign accept      = iReqValid && oReqReady;
  assign addr_unused = ^req_reg.addr[cXLEN-1:2];

  lsu_align u_align (
    .word        (iRamData),
    .addr_lo     (req_reg.addr[1:0]),
    .size        (req_reg.size),
    .is_unsigned (req_reg.is_unsigned),
    .store_data  (req_reg.data),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_comb begin
    state_next      = state_reg;
    req_next        = req_reg;
    ram_en_next     = 1'b0;
    ram_wen_next    = 1'b0;
    ram_addr_next   = ram_addr_reg;
    ram_data_next   = ram_data_reg;
    resp_valid_next = 1'b0;
    resp_data_next  = resp_data_reg;
    misalign_next   = 1'b0;
    case (state_reg)
      sIdle: begin
        if (accept) begin
          if (ls_misaligned(in_size, iReqAddr[1:0])) begin
            misalign_next = 1'b1;
          end else begin
            req_next      = '{write: iReqWrite, size: in_size, is_unsigned: iReqUnsigned,
                              addr: iReqAddr, data: iReqData};
            state_next    = sIssue;
            // RAM signals are registered here so they are live throughout sIssue.
            ram_en_next   = 1'b1;
            ram_wen_next  = iReqWrite && (in_size == szWord);
            ram_addr_next = iReqAddr[cAW+1:2];
            if (iReqWrite && (in_size == szWord)) ram_data_next = iReqData;
          end
        end
      end
      sIssue: begin
        if (!req_reg.write)             state_next = sLdData;
        else if (req_reg.size == szWord) state_next = sIdle;
        else                            state_next = sRmwData;
      end
      sLdData: begin
        resp_data_next  = load_data;
        resp_valid_next = 1'b1;
        state_next      = sIdle;
      end
      sRmwData: begin
        ram_en_next   = 1'b1;
        ram_wen_next  = 1'b1;
        ram_data_next = merged_data;
        state_next    = sRmwWrite;
      end
      sRmwWrite: state_next = sIdle;
      default:   state_next = sIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_reg      <= sIdle;
      req_reg        <= '0;
      ram_en_reg     <= 1'b0;
      ram_wen_reg    <= 1'b0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      ram_en_reg     <= ram_en_next;
      ram_wen_reg    <= ram_wen_next;
      ram_addr_reg   <= ram_addr_next;
      ram_data_reg   <= ram_data_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
      misalign_reg   <= misalign_next;
    end
  end

  assign oRamEn     = ram_en_reg;
  assign oRamWEn    = ram_wen_reg;
  assign oRamAddr   = ram_addr_reg;
  assign oRamData   = ram_data_reg;
  assign oRespValid = resp_valid_reg;
  assign oRespData  = resp_data_reg;
  assign oMisalign  = misalign_reg;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: vector table, directed reset/back-to-back sequences, random vs byte-level model.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int K_LOAD = 0;
  localparam int K_WORD = 1;
  localparam int K_SUB  = 2;
  localparam int K_MIS  = 3;

  typedef struct {
    int          mis_k;
    int          resp_k;
    logic [31:0] resp_data;
    int          wr_k;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    int          en_count;
  } obs_t;

  typedef struct {
    bit          w;
    logic [1:0]  sz;
    bit          u;
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    logic [31:0] exp_val;
  } vec_t;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iReqValid = 1'b0;
  logic        oReqReady;
  logic        iReqWrite = 1'b0;
  logic [1:0]  iReqSize = 2'b00;
  logic        iReqUnsigned = 1'b0;
  logic [31:0] iReqAddr = '0;
  logic [31:0] iReqData = '0;
  logic        oRespValid;
  logic [31:0] oRespData;
  logic        oMisalign;
  logic        oRamEn;
  logic        oRamWEn;
  logic [9:0]  oRamAddr;
  logic [31:0] oRamData;
  logic [31:0] iRamData = '0;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;
  bit mon_on = 1'b0;

  logic [31:0] ram [0:1023];
  logic [7:0]  mdl [0:4095];

  lsu_mem_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqWrite(iReqWrite), .iReqSize(iReqSize), .iReqUnsigned(iReqUnsigned),
    .iReqAddr(iReqAddr), .iReqData(iReqData), .oRespValid(oRespValid),
    .oRespData(oRespData), .oMisalign(oMisalign), .oRamEn(oRamEn), .oRamWEn(oRamWEn),
    .oRamAddr(oRamAddr), .oRamData(oRamData), .iRamData(iRamData)
  );

  always #5 iClk = ~iClk;

  // Bench-side RAM with registered read, as seen on port B.
  always @(posedge iClk) begin
    if (oRamEn) begin
      if (oRamWEn) ram[oRamAddr] <= oRamData;
      iRamData <= ram[oRamAddr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (mon_on) check("wen_implies_en", 32'(oRamWEn & ~oRamEn), 32'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-addressed reference model; addresses wrap at 4 KiB (1024 words).
  function automatic logic [31:0] mdl_word(logic [31:0] a);
    int b;
    b = int'({a[11:2], 2'b00});
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  function automatic bit misaligned(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mdl_load(logic [1:0] sz, bit u, logic [31:0] a);
    logic [31:0] v;
    int n, b;
    v = '0;
    n = 1 << sz;
    b = int'(a[11:0]);
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[b+i];
    if (!u && n < 4 && v[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int n, b;
    n = 1 << sz;
    b = int'(a[11:0]);
    for (int i = 0; i < n; i++) mdl[b+i] = d[8*i +: 8];
  endtask

  // Latencies counted in samples after the accept edge (sample k sits between E(k) and E(k+1)).
  function automatic obs_t exp_obs(int kind, logic [31:0] val, logic [31:0] a);
    obs_t e;
    e.mis_k = -1; e.resp_k = -1; e.wr_k = -1; e.en_count = 0;
    e.resp_data = '0; e.wr_addr = 32'(a[11:2]); e.wr_data = val;
    case (kind)
      K_MIS:   e.mis_k = 0;
      K_LOAD:  begin e.resp_k = 2; e.en_count = 1; e.resp_data = val; end
      K_WORD:  begin e.wr_k = 0; e.en_count = 1; end
      default: begin e.wr_k = 2; e.en_count = 2; end
    endcase
    return e;
  endfunction

  task automatic wait_ready(input string tag);
    int waited;
    waited = 0;
    @(negedge iClk);
    while (!oReqReady && waited < 20) begin
      @(negedge iClk);
      waited++;
    end
    check({tag, ".ready"}, 32'(oReqReady), 32'd1);
  endtask

  task automatic run_req(input string tag, input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] d, output obs_t o);
    o.mis_k = -1; o.resp_k = -1; o.wr_k = -1; o.en_count = 0;
    o.resp_data = '0; o.wr_addr = '0; o.wr_data = '0;
    wait_ready(tag);
    iReqValid = 1'b1; iReqWrite = w; iReqSize = sz; iReqUnsigned = u;
    iReqAddr = a; iReqData = d;
    @(posedge iClk);
    #1;
    // Scramble the request fields: the DUT must have captured them at accept.
    iReqValid = 1'b0; iReqWrite = 1'($urandom); iReqSize = 2'($urandom);
    iReqUnsigned = 1'($urandom); iReqAddr = $urandom; iReqData = $urandom;
    for (int k = 0; k < 5; k++) begin
      @(negedge iClk);
      if (oMisalign && o.mis_k < 0) o.mis_k = k;
      if (oRespValid && o.resp_k < 0) begin o.resp_k = k; o.resp_data = oRespData; end
      if (oRamEn) o.en_count++;
      if (oRamEn && oRamWEn && o.wr_k < 0) begin
        o.wr_k = k; o.wr_addr = 32'(oRamAddr); o.wr_data = oRamData;
      end
    end
    txn_no++;
    $display("txn %0d %s: %s sz=%0d uns=%0d addr=%h data=%h resp_k=%0d resp=%h mis_k=%0d wr_k=%0d wdata=%h",
             txn_no, tag, w ? "ST" : "LD", sz, u, a, d, o.resp_k, o.resp_data, o.mis_k, o.wr_k, o.wr_data);
  endtask

  task automatic compare(input string tag, input obs_t o, input obs_t e, input int kind);
    check({tag, ".mis_k"}, 32'(o.mis_k), 32'(e.mis_k));
    check({tag, ".resp_k"}, 32'(o.resp_k), 32'(e.resp_k));
    check({tag, ".wr_k"}, 32'(o.wr_k), 32'(e.wr_k));
    check({tag, ".en_count"}, 32'(o.en_count), 32'(e.en_count));
    if (kind == K_LOAD) check({tag, ".resp_data"}, o.resp_data, e.resp_data);
    if (kind == K_WORD || kind == K_SUB) begin
      check({tag, ".wr_addr"}, o.wr_addr, e.wr_addr);
      check({tag, ".wr_data"}, o.wr_data, e.wr_data);
    end
  endtask

  task automatic rst_check(input string tag);
    check({tag, ".ctl"}, 32'({oRamEn, oRamWEn, oRespValid, oMisalign, oReqReady}), 32'd0);
    check({tag, ".ram_addr"}, 32'(oRamAddr), 32'd0);
    check({tag, ".ram_data"}, oRamData, 32'd0);
    check({tag, ".resp_data"}, oRespData, 32'd0);
  endtask

  vec_t vecs [14];

  initial begin
    obs_t o;
    int en_seen, resp_seen, bad;
    bit prev_en;
    bit w, u;
    logic [1:0] sz;
    logic [31:0] a, d, val, wexp;
    int kind;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, K_WORD, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         K_LOAD, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1122_3344, K_WORD, 32'h1122_3344};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h5555_55AA, K_SUB,  32'hAA22_3344};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         K_LOAD, 32'hFFFF_FFAA};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         K_LOAD, 32'h0000_00AA};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0,         K_LOAD, 32'hFFFF_AA22};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0012, 32'h0,         K_MIS,  32'h0};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_1010, 32'h0,         K_LOAD, 32'hAA22_3344};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_1012, 32'h1234_BEEF, K_SUB,  32'hBEEF_3344};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0,         K_MIS,  32'h0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_7777, K_MIS,  32'h0};
    vecs[12] = '{1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'h0,         K_LOAD, 32'h0000_3344};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0000_0011, 32'h0,         K_LOAD, 32'h0000_0033};

    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      for (int b = 0; b < 4; b++) mdl[4*i+b] = ram[i][8*b +: 8];
    end

    // Power-on reset held for three cycles.
    repeat (3) begin
      @(negedge iClk);
      rst_check("rst_init");
    end
    iRst = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d, o);
      compare($sformatf("vec%0d", i), o, exp_obs(vecs[i].kind, vecs[i].exp_val, vecs[i].a), vecs[i].kind);
      if (vecs[i].kind == K_WORD || vecs[i].kind == K_SUB)
        mdl_store(vecs[i].sz, vecs[i].a, vecs[i].d);
    end
    check("vec_ram_word4", ram[4], 32'hBEEF_3344);

    // Reset asserted while the RMW is in sRmwData: the partial write must be dropped.
    wait_ready("rst_rmw");
    iReqValid = 1'b1; iReqWrite = 1'b1; iReqSize = 2'd0; iReqUnsigned = 1'b0;
    iReqAddr = 32'h20; iReqData = 32'h5A;
    @(posedge iClk);
    #1 iReqValid = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    en_seen = 0;
    repeat (3) begin
      @(negedge iClk);
      rst_check("rst_mid_rmw");
      en_seen += int'(oRamEn);
    end
    iRst = 1'b1;
    @(negedge iClk);
    check("rst_release_ready", 32'(oReqReady), 32'd1);
    repeat (5) begin
      @(negedge iClk);
      en_seen += int'(oRamEn);
    end
    check("rst_no_access", 32'(en_seen), 32'd0);
    check("rst_ram_kept", ram[8], mdl_word(32'h20));
    $display("txn %0d rst_rmw: byte store @20 interrupted, ram[8]=%h", ++txn_no, ram[8]);

    // Reset in the cycle a word store is driven: that write still lands.
    wait_ready("rst_word");
    iReqValid = 1'b1; iReqWrite = 1'b1; iReqSize = 2'd2; iReqAddr = 32'h24; iReqData = 32'hCAFE_F00D;
    @(posedge iClk);
    #1 iReqValid = 1'b0;
    @(negedge iClk);
    check("rst_word_strobe", 32'({oRamEn, oRamWEn}), 32'd3);
    iRst = 1'b0;
    @(negedge iClk);
    rst_check("rst_word");
    iRst = 1'b1;
    @(negedge iClk);
    mdl_store(2'd2, 32'h24, 32'hCAFE_F00D);
    check("rst_word_completes", ram[9], 32'hCAFE_F00D);
    $display("txn %0d rst_word: word store @24 under reset, ram[9]=%h", ++txn_no, ram[9]);

    // Valid held high on word loads at 0x1010: one accept per idle, no enable overlap.
    wait_ready("held");
    iReqValid = 1'b1; iReqWrite = 1'b0; iReqSize = 2'd2; iReqUnsigned = 1'b0;
    iReqAddr = 32'h1010; iReqData = '0;
    @(posedge iClk);
    en_seen = 0; resp_seen = 0; prev_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge iClk);
      if (oRamEn) begin
        en_seen++;
        check("held_addr", 32'(oRamAddr), 32'd4);
      end
      if (prev_en && oRamEn) check("held_en_overlap", 32'd1, 32'd0);
      prev_en = oRamEn;
      if (oRespValid) begin
        resp_seen++;
        check("held_resp_data", oRespData, mdl_word(32'h1010));
      end
    end
    iReqValid = 1'b0;
    check("held_en_count", 32'(en_seen), 32'd4);
    check("held_resp_count", 32'(resp_seen), 32'd4);
    $display("txn %0d held: 12 cycles of held loads, en=%0d resp=%0d", ++txn_no, en_seen, resp_seen);

    // Random requests against the byte-level model.
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        else if (sz == 2'd1) a[0] = 1'b0;
      end
      if (misaligned(sz, a)) begin
        kind = K_MIS; val = '0;
      end else if (!w) begin
        kind = K_LOAD; val = mdl_load(sz, u, a);
      end else begin
        mdl_store(sz, a, d);
        kind = (sz == 2'd2) ? K_WORD : K_SUB;
        val = mdl_word(a);
      end
      wexp = val;
      run_req($sformatf("rnd%0d", n), w, sz, u, a, d, o);
      compare($sformatf("rnd%0d", n), o, exp_obs(kind, wexp, a), kind);
    end

    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (ram[i] !== mdl_word(32'(i * 4))) bad++;
    end
    check("ram_sweep", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
